// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the tone generator and its helpers.
//   - tone_state_t : FSM states (IDLE, PLAY, DONE)
//   - DUR_W, HP_W, GAP_MS : default field widths / gap length
//   - HP_TABLE / hp_lookup : half-period in clk cycles per pitch code
//     (calibrated for 100 clk cycles per ms; entry 0 is the rest code)
package tone_pkg;

  localparam int DUR_W  = 12;
  localparam int HP_W   = 8;
  localparam int GAP_MS = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } tone_state_t;

  // C4..C6, one entry per pitch code 1..15
  localparam logic [HP_W-1:0] HP_TABLE [16] = '{
    8'd0,   8'd191, 8'd170, 8'd152, 8'd143, 8'd128, 8'd114, 8'd101,
    8'd96,  8'd85,  8'd76,  8'd72,  8'd64,  8'd57,  8'd51,  8'd48
  };

  function automatic logic [HP_W-1:0] hp_lookup(input logic [3:0] pitch);
    return HP_TABLE[pitch];
  endfunction

endpackage

// File: rtl/ms_timer.sv
// ms_timer: millisecond timebase with duration expiry.
//   clk, rst        : clock, synchronous active-high reset
//   load            : latch ticks_per_milli and dur, clear counters
//   run             : advance the prescaler this cycle
//   ticks_per_milli : clk cycles per ms (0 treated as 1)
//   dur             : duration in ms
//   ms_tick         : prescaler wraps this cycle (one ms completes)
//   ms_cnt          : completed ms since load
//   expired         : this cycle is the last cycle of the duration
module ms_timer #(
  parameter int DUR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [15:0]      ticks_per_milli,
  input  logic [DUR_W-1:0] dur,
  output logic             ms_tick,
  output logic [DUR_W-1:0] ms_cnt,
  output logic             expired
);

  logic [15:0]      pre;
  logic [15:0]      pre_max;
  logic [DUR_W-1:0] dur_lat;

  assign ms_tick = run && (pre == pre_max);
  // dur_lat==0 never runs; the owner skips straight past the timed phase
  assign expired = ms_tick && (ms_cnt == dur_lat - DUR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      pre_max <= '0;
      ms_cnt  <= '0;
      dur_lat <= '0;
    end else if (load) begin
      pre     <= '0;
      pre_max <= (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
      ms_cnt  <= '0;
      dur_lat <= dur;
    end else if (ms_tick) begin
      pre <= '0;
      // hold at the final count so ms_cnt never wraps
      if (!expired) ms_cnt <= ms_cnt + DUR_W'(1);
    end else if (run) begin
      pre <= pre + 16'd1;
    end
  end

endmodule

// File: rtl/tone_generator.sv
// tone_generator: plays one note command as a square wave on 'sound'.
//   clk, rst        : clock, synchronous active-high reset
//   ticks_per_milli : clk cycles per ms, latched at accept (0 -> 1)
//   note_valid/ready: command handshake; ready only in IDLE
//   note_pitch      : 0 = rest, 1..15 = C4..C6
//   note_ms         : duration in ms
//   sound           : square-wave speaker drive (registered)
//   playing         : high while a note or rest is in PLAY
//   note_done       : one-cycle pulse after the note ends
// Build option: define TONE_GAP_EN to silence the last GAP_MS ms of
// pitched notes longer than GAP_MS (articulation gap).
module tone_generator #(
  parameter int DUR_W  = 12,
  parameter int HP_W   = 8,
  parameter int GAP_MS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ticks_per_milli,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note_pitch,
  input  logic [DUR_W-1:0] note_ms,
  output logic             sound,
  output logic             playing,
  output logic             note_done
);

  import tone_pkg::*;

  localparam logic [DUR_W-1:0] GAP_LEN = DUR_W'(GAP_MS);

  tone_state_t      state, state_nxt;
  logic             accept;
  logic             ms_tick, expired;
  logic [DUR_W-1:0] ms_cnt;
  logic [3:0]       pitch_lat;
  logic [HP_W-1:0]  hp_cnt, hp_val;
  logic             wave, wave_nxt, hp_wrap;
  logic             gap_nxt;

  assign accept     = note_valid && (state == IDLE);
  assign note_ready = (state == IDLE);
  assign playing    = (state == PLAY);
  assign note_done  = (state == DONE);

  ms_timer #(.DUR_W(DUR_W)) u_ms_timer (
    .clk             (clk),
    .rst             (rst),
    .load            (accept),
    .run             (state == PLAY),
    .ticks_per_milli (ticks_per_milli),
    .dur             (note_ms),
    .ms_tick         (ms_tick),
    .ms_cnt          (ms_cnt),
    .expired         (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (note_valid) state_nxt = (note_ms == '0) ? DONE : PLAY;
      PLAY:    if (expired)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Half-period stepping; a rest has hp_val==0 and simply never toggles.
  always_comb begin
    hp_val   = HP_W'(hp_lookup(pitch_lat));
    hp_wrap  = (hp_cnt == hp_val - HP_W'(1));
    wave_nxt = (pitch_lat != 4'd0) && (hp_wrap ? !wave : wave);
  end

`ifdef TONE_GAP_EN
  logic             gap_on, gap_en_lat;
  logic [DUR_W-1:0] gap_start;

  // Gap begins on the ms wrap that enters ms index (duration - GAP_MS).
  assign gap_nxt = gap_on ||
                   (gap_en_lat && ms_tick && (ms_cnt + DUR_W'(1) == gap_start));

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_on     <= 1'b0;
      gap_en_lat <= 1'b0;
      gap_start  <= '0;
    end else if (accept) begin
      gap_on     <= 1'b0;
      gap_en_lat <= (note_pitch != 4'd0) && (note_ms > GAP_LEN);
      gap_start  <= note_ms - GAP_LEN;
    end else if (state == PLAY && !expired) begin
      gap_on <= gap_nxt;
    end else begin
      gap_on <= 1'b0;
    end
  end
`else
  logic gap_unused;
  assign gap_nxt    = 1'b0;
  assign gap_unused = ^{ms_cnt, GAP_LEN};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pitch_lat <= '0;
      hp_cnt    <= '0;
      wave      <= 1'b0;
      sound     <= 1'b0;
    end else if (accept) begin
      pitch_lat <= note_pitch;
      hp_cnt    <= '0;
      wave      <= (note_pitch != 4'd0) && (note_ms != '0);
      sound     <= (note_pitch != 4'd0) && (note_ms != '0);
    end else if (state == PLAY && !expired) begin
      hp_cnt <= (hp_wrap || pitch_lat == 4'd0) ? '0 : hp_cnt + HP_W'(1);
      wave   <= wave_nxt;
      sound  <= wave_nxt && !gap_nxt;
    end else begin
      hp_cnt <= '0;
      wave   <= 1'b0;
      sound  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;

  localparam int DUR_W = 12;
  localparam int GAP   = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      ticks_per_milli;
  logic             note_valid;
  logic             note_ready;
  logic [3:0]       note_pitch;
  logic [DUR_W-1:0] note_ms;
  logic             sound;
  logic             playing;
  logic             note_done;

  int n_vec  = 0;
  int n_err  = 0;

  int hp_ref [16] = '{0, 191, 170, 152, 143, 128, 114, 101,
                      96, 85, 76, 72, 64, 57, 51, 48};

  tone_generator #(.DUR_W(DUR_W), .HP_W(8), .GAP_MS(GAP)) dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .note_valid      (note_valid),
    .note_ready      (note_ready),
    .note_pitch      (note_pitch),
    .note_ms         (note_ms),
    .sound           (sound),
    .playing         (playing),
    .note_done       (note_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected speaker level k cycles after the accept edge.
  function automatic bit sound_ref(int t, int p, int ms, int k);
    int len;
    len = ms * t;
    if (p == 0 || k >= len) return 1'b0;
`ifdef TONE_GAP_EN
    if (ms > GAP && k >= (ms - GAP) * t) return 1'b0;
`endif
    return ((k / hp_ref[p]) % 2) == 0;
  endfunction

  // Called at the first negedge after the accept edge; ends at the negedge
  // where note_ready has come back.
  task automatic observe(input int t_raw, input int p, input int ms);
    int t, len, sound_err, play_err, done_err, ready_err;
    t = (t_raw == 0) ? 1 : t_raw;
    len = ms * t;
    sound_err = 0; play_err = 0; done_err = 0; ready_err = 0;
    for (int k = 0; k <= len + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (sound     !== sound_ref(t, p, ms, k)) sound_err++;
      if (playing   !== (k < len))              play_err++;
      if (note_done !== (k == len))             done_err++;
      if (note_ready !== (k == len + 1))        ready_err++;
    end
    chk($sformatf("sound_bad_cycles t=%0d p=%0d ms=%0d", t_raw, p, ms), sound_err, 0);
    chk($sformatf("playing_bad_cycles t=%0d p=%0d ms=%0d", t_raw, p, ms), play_err, 0);
    chk($sformatf("done_bad_cycles t=%0d p=%0d ms=%0d", t_raw, p, ms), done_err, 0);
    chk($sformatf("ready_bad_cycles t=%0d p=%0d ms=%0d", t_raw, p, ms), ready_err, 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!note_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", note_ready, 1);
  endtask

  // Accept one note, then scramble inputs to show they are ignored.
  task automatic play_note(input int t, input int p, input int ms);
    wait_ready();
    ticks_per_milli = 16'(t);
    note_pitch      = 4'(p);
    note_ms         = DUR_W'(ms);
    note_valid      = 1'b1;
    @(posedge clk);
    #1;
    note_valid      = 1'b0;
    note_pitch      = 4'($urandom);
    note_ms         = DUR_W'($urandom);
    ticks_per_milli = 16'($urandom);
    @(negedge clk);
    observe(t, p, ms);
  endtask

  initial begin
    int t_opts [5] = '{0, 1, 3, 10, 100};
    int t, p, ms;

    rst = 1'b1;
    note_valid = 1'b0;
    note_pitch = '0;
    note_ms = '0;
    ticks_per_milli = 16'd100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sound", sound, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", note_done, 0);
    chk("rst_ready", note_ready, 1);
    rst = 1'b0;

    play_note(100, 6, 5);
    play_note(10, 0, 3);
    play_note(100, 1, 0);
    play_note(10, 8, 50);
    play_note(10, 3, 20);

    // Valid held high: the second note waits for note_ready.
    wait_ready();
    ticks_per_milli = 16'd10;
    note_pitch = 4'd8;
    note_ms = DUR_W'(50);
    note_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    observe(10, 8, 50);
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    @(negedge clk);
    observe(10, 8, 50);

    // Randomised notes
    for (int i = 0; i < 25; i++) begin
      t  = t_opts[$urandom_range(0, 4)];
      p  = $urandom_range(0, 15);
      ms = (t >= 100) ? $urandom_range(0, 6) : $urandom_range(0, 30);
      play_note(t, p, ms);
    end

    // Reset in the middle of a note
    wait_ready();
    ticks_per_milli = 16'd100;
    note_pitch = 4'd15;
    note_ms = DUR_W'(10);
    note_valid = 1'b1;
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    repeat (299) @(posedge clk);
    @(negedge clk);
    chk("mid_playing_before_rst", playing, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_sound", sound, 0);
    chk("mid_rst_playing", playing, 0);
    chk("mid_rst_done", note_done, 0);
    chk("mid_rst_ready", note_ready, 1);
    begin
      int extra_done;
      extra_done = 0;
      repeat (1200) begin
        @(negedge clk);
        if (note_done || playing || sound) extra_done++;
      end
      chk("mid_rst_quiet_after", extra_done, 0);
    end

    // Short note after reset to show recovery
    play_note(3, 12, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
